// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between the MEM stage
// (master) and the multi-cycle data-memory responder (slave).
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time data-memory target with WAIT_CYCLES wait
// states and RV32I sub-word loads/stores on internal word storage.
// Optional macro DMEM_ERR_EN: reject misaligned or reserved-funct3 requests
// with rsp_err; without it, addresses are force-aligned and reserved codes
// behave as word accesses.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_responder_if.slave      bus,
  output logic                 busy
);
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              accept_c, access_c;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic              ready_q, rsp_valid_q, busy_q, err_q;
  logic [31:0]       rdata_q;

  logic [31:0]       mem [0:DEPTH-1];

  logic [IDX_W-1:0]  idx_c;
  logic [1:0]        size_c, lane_c;
  logic              err_c;
  logic [31:0]       word_c, shifted_c, load_c, wmask_c, wbytes_c, wnew_c;
`ifdef DMEM_ERR_EN
  logic              rsvd_c, misal_c;
`endif

  // Next-state decode: accept in IDLE, access when the wait count expires.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    access_c  = 1'b0;
    case (state)
      S_IDLE: if (bus.req_valid) begin
        accept_c  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        access_c  = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane steering, load extension and store merge for the latched request.
  always_comb begin
    idx_c = addr_q[ADDR_W-1:2];
    case (f3_q[1:0])
      2'b00:   size_c = SZ_B;
      2'b01:   size_c = SZ_H;
      default: size_c = SZ_W;
    endcase
`ifdef DMEM_ERR_EN
    rsvd_c  = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
    misal_c = ((size_c == SZ_H) && addr_q[0]) ||
              ((size_c == SZ_W) && (addr_q[1:0] != 2'b00));
    err_c   = rsvd_c || misal_c;
`else
    err_c   = 1'b0;
`endif
    case (size_c)
      SZ_B:    lane_c = addr_q[1:0];
      SZ_H:    lane_c = {addr_q[1], 1'b0};
      default: lane_c = 2'b00;
    endcase
    word_c    = mem[idx_c];
    shifted_c = word_c >> {lane_c, 3'b000};
    case (size_c)
      SZ_B: begin
        load_c   = f3_q[2] ? {24'h0, shifted_c[7:0]}
                           : {{24{shifted_c[7]}}, shifted_c[7:0]};
        wbytes_c = {4{wdata_q[7:0]}};
        wmask_c  = 32'h0000_00FF << {lane_c, 3'b000};
      end
      SZ_H: begin
        load_c   = f3_q[2] ? {16'h0, shifted_c[15:0]}
                           : {{16{shifted_c[15]}}, shifted_c[15:0]};
        wbytes_c = {2{wdata_q[15:0]}};
        wmask_c  = 32'h0000_FFFF << {lane_c, 3'b000};
      end
      default: begin
        load_c   = word_c;
        wbytes_c = wdata_q;
        wmask_c  = 32'hFFFF_FFFF;
      end
    endcase
    wnew_c = (word_c & ~wmask_c) | (wbytes_c & wmask_c);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Request latch, wait counter and registered response/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      f3_q        <= 3'b000;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      ready_q     <= (state_nxt == S_IDLE);
      rsp_valid_q <= (state_nxt == S_RESP);
      busy_q      <= (state_nxt != S_IDLE);
      if (accept_c) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_funct3;
        cnt_q   <= 4'(WAIT_CYCLES);
      end else if ((state == S_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access_c) begin
        err_q   <= err_c;
        rdata_q <= (we_q || err_c) ? 32'h0 : load_c;
      end
    end
  end

  // Word storage; not reset, written only by an accepted, non-rejected store.
  always_ff @(posedge clk) begin
    if (access_c && we_q && !err_c) mem[idx_c] <= wnew_c;
  end

  assign bus.req_ready = ready_q & rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = busy_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the target side of the pipeline's MEM-stage data access (read/write strobe, byte address, store data, funct3 width code). It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, and performs RV32I sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) on internal word storage. It returns read data and status over a second valid/ready handshake. It replaces the single-cycle data memory so the core can be tested against slow memory.

## Interface
- ADDR_W, 8, byte-address width; storage depth is 2^(ADDR_W-2) words.
- WAIT_CYCLES, 2, wait states inserted between acceptance and access (0..15).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE with rst high.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, lane-0 justified (rs2 value).
- req_funct3  in  3  width/sign code, RV32I encoding.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator takes response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned or reserved funct3).
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/funct3, load wait counter with WAIT_CYCLES, go to WAIT.
- WAIT: if counter != 0, decrement. If counter == 0, perform the access at this edge, register rsp_rdata/rsp_err, and go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready, then go to IDLE.
- Lane selection: word index addr[ADDR_W-1:2], byte lane addr[1:0], half lane addr[1].
- Loads: LB (000) and LH (001) sign-extend. LBU (100) and LHU (101) zero-extend. LW (010) returns the whole word.
- Stores: SB (000) writes one byte lane, SH (001) writes two byte lanes, SW (010) writes all four. Other lanes are untouched.
- Storage contents are not reset.
- Requests are not pipelined. req_valid held while busy is ignored until IDLE.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, counter 0. req_ready is 0 while rst is low.
- Latency: request accepted at edge T means rsp_valid is high after edge T+WAIT_CYCLES+1.
- Storage write occurs at that same edge.
- Minimum request spacing is WAIT_CYCLES+3 cycles, with rsp_ready held high.
- rsp_ready low in RESP stalls indefinitely with outputs frozen.
- rsp_ready high outside RESP is ignored.
- Reset asserted in WAIT: return to IDLE immediately. The pending store is dropped (no write) and no response is produced.
- Reset asserted in RESP: the response is discarded and rsp_valid drops asynchronously.
- The address wraps naturally within ADDR_W. No out-of-range condition exists.

## Configuration
- DMEM_ERR_EN defined:
  - Misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) accesses, and reserved funct3 (011, 110, 111), produce rsp_err=1 and rsp_rdata=0.
  - A rejected store leaves storage unchanged.
  - Latency is unchanged.
- DMEM_ERR_EN undefined:
  - rsp_err is tied 0.
  - Misaligned addresses are truncated to natural alignment (halfword clears addr[0], word clears addr[1:0]).
  - Reserved funct3 values are treated as word (LW/SW).

## Test plan
- WAIT_CYCLES=2: SW 0xDEADBEEF at 0x10, then LW 0x10. Expect rdata 0xDEADBEEF, rsp_valid exactly 3 edges after each acceptance, rsp_err 0.
- After the above, SB 0x7F at 0x11, then LB 0x13 and LBU 0x13. Expect 0xFFFFFFDE and 0x000000DE; LW 0x10 returns 0xDEAD7FEF.
- SH 0x8001 at 0x22, then LH 0x22 and LHU 0x22. Expect 0xFFFF8001 and 0x00008001; lower half of word 0x20 unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP. Expect rsp_valid/rsp_rdata stable, req_ready=0 and busy=1 throughout; IDLE is reached the cycle after rsp_ready rises.
- DMEM_ERR_EN: SW 0x12345678 at 0x31. Expect rsp_err=1, rdata 0, and LW 0x30 unchanged. Without the macro, the same store lands at 0x30 and LW 0x30 returns 0x12345678.
- Issue SW 0xAAAAAAAA at 0x40 and assert rst during WAIT. Expect no response, busy=0, and LW 0x40 returning its prior value.
